// File: rtl/pipe_ctrl_tracker.sv
// rtl/pipe_ctrl_tracker.sv - D/X, X/M, M/W control tracking, bubbles and EX forwarding selects (option: PIPE_CTRL_STATS_EN)
module pipe_ctrl_tracker #(
  parameter int REG_W = 4,
  parameter int MTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic             id_reg_write,
  input  logic [MTR_W-1:0] id_mem_to_reg,
  input  logic [REG_W-1:0] id_dst_reg,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  output logic [MTR_W-1:0] dx_mem_to_reg,
  output logic [REG_W-1:0] dx_dst_reg,
  output logic [REG_W-1:0] xm_dst_reg,
  output logic [REG_W-1:0] mw_dst_reg,
  output logic             mw_reg_write,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             fwd_err
`ifdef PIPE_CTRL_STATS_EN
  ,
  output logic [15:0]      bubble_cnt
`endif
);

  localparam logic [MTR_W-1:0] MTR_LOAD = '1;

  logic             r_dx_valid, r_dx_rw;
  logic [MTR_W-1:0] r_dx_mtr;
  logic [REG_W-1:0] r_dx_dst, r_dx_src1, r_dx_src2;
  logic             r_xm_valid, r_xm_rw;
  logic [MTR_W-1:0] r_xm_mtr;
  logic [REG_W-1:0] r_xm_dst;
  logic             r_mw_valid, r_mw_rw;
  logic [REG_W-1:0] r_mw_dst;
  logic             r_fwd_err;

  logic w_adv;
  logic w_hz_bubble;
  logic w_capture;
  logic w_xm_fwd_ok;
  logic w_mw_fwd_ok;
  logic w_ld_hazard;

  assign w_adv       = ~freeze;
  assign w_hz_bubble = stall | flush;
  // A NOP from decode is stored as an all-zero bubble just like a hazard bubble.
  assign w_capture   = id_valid & ~w_hz_bubble;

  // Advance all three stage registers together unless the pipeline is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dx_valid <= 1'b0;
      r_dx_rw    <= 1'b0;
      r_dx_mtr   <= '0;
      r_dx_dst   <= '0;
      r_dx_src1  <= '0;
      r_dx_src2  <= '0;
      r_xm_valid <= 1'b0;
      r_xm_rw    <= 1'b0;
      r_xm_mtr   <= '0;
      r_xm_dst   <= '0;
      r_mw_valid <= 1'b0;
      r_mw_rw    <= 1'b0;
      r_mw_dst   <= '0;
    end else if (w_adv) begin
      r_dx_valid <= w_capture;
      r_dx_rw    <= w_capture ? id_reg_write  : 1'b0;
      r_dx_mtr   <= w_capture ? id_mem_to_reg : '0;
      r_dx_dst   <= w_capture ? id_dst_reg    : '0;
      r_dx_src1  <= w_capture ? id_src1       : '0;
      r_dx_src2  <= w_capture ? id_src2       : '0;
      r_xm_valid <= r_dx_valid;
      r_xm_rw    <= r_dx_rw;
      r_xm_mtr   <= r_dx_mtr;
      r_xm_dst   <= r_dx_dst;
      r_mw_valid <= r_xm_valid;
      r_mw_rw    <= r_xm_rw;
      r_mw_dst   <= r_xm_dst;
    end
  end

  // A load still in X/M has no data yet, so it can only be bypassed from M/W.
  assign w_xm_fwd_ok = r_dx_valid & r_xm_valid & r_xm_rw & (r_xm_dst != '0) & (r_xm_mtr != MTR_LOAD);
  assign w_mw_fwd_ok = r_mw_valid & r_mw_rw & (r_mw_dst != '0);
  assign w_ld_hazard = r_dx_valid & r_xm_valid & (r_xm_mtr == MTR_LOAD) & (r_xm_dst != '0)
                     & ((r_xm_dst == r_dx_src1) | (r_xm_dst == r_dx_src2));

  // Per-operand bypass select; X/M wins because it carries the younger result.
  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (w_xm_fwd_ok && (r_xm_dst == r_dx_src1))      fwd_a_sel = 2'b10;
    else if (w_mw_fwd_ok && (r_mw_dst == r_dx_src1)) fwd_a_sel = 2'b01;
    if (w_xm_fwd_ok && (r_xm_dst == r_dx_src2))      fwd_b_sel = 2'b10;
    else if (w_mw_fwd_ok && (r_mw_dst == r_dx_src2)) fwd_b_sel = 2'b01;
  end

  // Sticky record that a load-use pair reached EX without the required stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_fwd_err <= 1'b0;
    else if (w_adv && w_ld_hazard) r_fwd_err <= 1'b1;
  end

`ifdef PIPE_CTRL_STATS_EN
  logic [15:0] r_bubble_cnt;

  // Count hazard bubbles entering D/X, saturating instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_bubble_cnt <= 16'h0000;
    else if (w_adv && w_hz_bubble && (r_bubble_cnt != 16'hFFFF))
      r_bubble_cnt <= r_bubble_cnt + 16'h0001;
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

  assign dx_mem_to_reg = r_dx_mtr;
  assign dx_dst_reg    = r_dx_dst;
  assign xm_dst_reg    = r_xm_dst;
  assign mw_dst_reg    = r_mw_dst;
  assign mw_reg_write  = r_mw_rw;
  assign fwd_err       = r_fwd_err;

endmodule

// File: tb/tb_pipe_ctrl_tracker.sv
// tb/tb_pipe_ctrl_tracker.sv - scoreboard bench for pipe_ctrl_tracker
module tb_pipe_ctrl_tracker;

  localparam int S_DX_MTR = 0, S_DX_DST = 1, S_XM_DST = 2, S_MW_DST = 3,
                 S_MW_RW = 4, S_FA = 5, S_FB = 6, S_ERR = 7, S_BC = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       freeze, stall, flush;
  logic       id_valid, id_reg_write;
  logic [1:0] id_mem_to_reg;
  logic [3:0] id_dst_reg, id_src1, id_src2;
  logic [1:0] dx_mem_to_reg;
  logic [3:0] dx_dst_reg, xm_dst_reg, mw_dst_reg;
  logic       mw_reg_write;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       fwd_err;
`ifdef PIPE_CTRL_STATS_EN
  logic [15:0] bubble_cnt;
`endif

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pipe_ctrl_tracker #(.REG_W(4), .MTR_W(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .freeze        (freeze),
    .stall         (stall),
    .flush         (flush),
    .id_valid      (id_valid),
    .id_reg_write  (id_reg_write),
    .id_mem_to_reg (id_mem_to_reg),
    .id_dst_reg    (id_dst_reg),
    .id_src1       (id_src1),
    .id_src2       (id_src2),
    .dx_mem_to_reg (dx_mem_to_reg),
    .dx_dst_reg    (dx_dst_reg),
    .xm_dst_reg    (xm_dst_reg),
    .mw_dst_reg    (mw_dst_reg),
    .mw_reg_write  (mw_reg_write),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel),
    .fwd_err       (fwd_err)
`ifdef PIPE_CTRL_STATS_EN
    ,
    .bubble_cnt    (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      S_DX_MTR: observe = {14'd0, dx_mem_to_reg};
      S_DX_DST: observe = {12'd0, dx_dst_reg};
      S_XM_DST: observe = {12'd0, xm_dst_reg};
      S_MW_DST: observe = {12'd0, mw_dst_reg};
      S_MW_RW:  observe = {15'd0, mw_reg_write};
      S_FA:     observe = {14'd0, fwd_a_sel};
      S_FB:     observe = {14'd0, fwd_b_sel};
      S_ERR:    observe = {15'd0, fwd_err};
`ifdef PIPE_CTRL_STATS_EN
      S_BC:     observe = bubble_cnt;
`endif
      default:  observe = 16'hDEAD;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [15:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic drive(input logic fz, input logic st, input logic fl, input logic v,
                       input logic rw, input logic [1:0] mtr, input logic [3:0] dst,
                       input logic [3:0] s1, input logic [3:0] s2);
    freeze = fz; stall = st; flush = fl; id_valid = v; id_reg_write = rw;
    id_mem_to_reg = mtr; id_dst_reg = dst; id_src1 = s1; id_src2 = s2;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    drain();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 2'b00, 4'd0, 4'd0, 4'd0);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 1, 0, 1, 1, 2'b11, 4'd7, 4'd7, 4'd7);
    repeat (3) @(negedge clk);
    for (int s = S_DX_MTR; s <= S_ERR; s++) expect_val("reset_out", s, 16'h0);
`ifdef PIPE_CTRL_STATS_EN
    expect_val("reset_bc", S_BC, 16'h0);
`endif
    drain();
    rst_n = 1'b1;

    // latency: R3 through the three stages
    drive(0, 0, 0, 1, 1, 2'b00, 4'd3, 4'd0, 4'd0);
    expect_val("lat_dx", S_DX_DST, 16'd3);
    tick();
    idle(0);
    drive(0, 0, 0, 0, 0, 2'b00, 4'd0, 4'd0, 4'd0);
    expect_val("lat_xm", S_XM_DST, 16'd3);
    expect_val("lat_dx_clr", S_DX_DST, 16'd0);
    tick();
    expect_val("lat_mw", S_MW_DST, 16'd3);
    expect_val("lat_mw_rw", S_MW_RW, 16'd1);
    tick();
    expect_val("lat_mw_clr", S_MW_DST, 16'd0);
    tick();

    // EX-EX forward: ADD R5 then SUB R5,R2
    drive(0, 0, 0, 1, 1, 2'b00, 4'd5, 4'd1, 4'd2);
    tick();
    drive(0, 0, 0, 1, 1, 2'b00, 4'd6, 4'd5, 4'd2);
    expect_val("exex_a", S_FA, 16'h2);
    expect_val("exex_b", S_FB, 16'h0);
    tick();
    idle(3);

    // MEM-EX forward with an unrelated instruction between
    drive(0, 0, 0, 1, 1, 2'b00, 4'd5, 4'd1, 4'd2);
    tick();
    drive(0, 0, 0, 1, 1, 2'b00, 4'd9, 4'd1, 4'd1);
    tick();
    drive(0, 0, 0, 1, 1, 2'b00, 4'd6, 4'd5, 4'd2);
    expect_val("memex_a", S_FA, 16'h1);
    expect_val("memex_b", S_FB, 16'h0);
    tick();
    idle(3);

    // priority: both X/M and M/W write R5, operand B reads R5
    drive(0, 0, 0, 1, 1, 2'b00, 4'd5, 4'd1, 4'd1);
    tick();
    drive(0, 0, 0, 1, 1, 2'b00, 4'd5, 4'd2, 4'd2);
    tick();
    drive(0, 0, 0, 1, 1, 2'b00, 4'd8, 4'd3, 4'd5);
    expect_val("prio_a", S_FA, 16'h0);
    expect_val("prio_b", S_FB, 16'h2);
    tick();
    idle(3);

    // load-use with correct stall
    drive(0, 0, 0, 1, 1, 2'b11, 4'd4, 4'd1, 4'd1);
    expect_val("lu_dx_mtr", S_DX_MTR, 16'h3);
    tick();
    drive(0, 1, 0, 1, 1, 2'b00, 4'd8, 4'd1, 4'd4);
    expect_val("lu_bubble_dst", S_DX_DST, 16'd0);
    expect_val("lu_bubble_mtr", S_DX_MTR, 16'd0);
    expect_val("lu_xm", S_XM_DST, 16'd4);
`ifdef PIPE_CTRL_STATS_EN
    expect_val("lu_bc", S_BC, 16'd1);
`endif
    tick();
    drive(0, 0, 0, 1, 1, 2'b00, 4'd8, 4'd1, 4'd4);
    expect_val("lu_dx", S_DX_DST, 16'd8);
    expect_val("lu_fb", S_FB, 16'h1);
    expect_val("lu_fa", S_FA, 16'h0);
    expect_val("lu_err", S_ERR, 16'h0);
    tick();
    idle(3);
    expect_val("lu_err_after", S_ERR, 16'h0);
    drain();

    // freeze beats stall
    drive(0, 0, 0, 1, 1, 2'b00, 4'd10, 4'd0, 4'd0);
    tick();
    drive(0, 0, 0, 1, 1, 2'b00, 4'd11, 4'd0, 4'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 1, 1, 2'b01, 4'd12, 4'd0, 4'd0);
      expect_val("frz_dx", S_DX_DST, 16'd11);
      expect_val("frz_xm", S_XM_DST, 16'd10);
      expect_val("frz_mw", S_MW_DST, 16'd0);
`ifdef PIPE_CTRL_STATS_EN
      expect_val("frz_bc", S_BC, 16'd1);
`endif
      tick();
    end
    drive(0, 1, 0, 1, 1, 2'b01, 4'd12, 4'd0, 4'd0);
    expect_val("unfrz_dx", S_DX_DST, 16'd0);
    expect_val("unfrz_xm", S_XM_DST, 16'd11);
    expect_val("unfrz_mw", S_MW_DST, 16'd10);
`ifdef PIPE_CTRL_STATS_EN
    expect_val("unfrz_bc", S_BC, 16'd2);
`endif
    tick();
    idle(3);

    // R0 never forwards
    drive(0, 0, 0, 1, 1, 2'b00, 4'd0, 4'd1, 4'd1);
    tick();
    drive(0, 0, 0, 1, 1, 2'b00, 4'd7, 4'd0, 4'd0);
    expect_val("r0_a", S_FA, 16'h0);
    expect_val("r0_b", S_FB, 16'h0);
    tick();

    // stall+flush give one bubble; flush alone another; NOP is not counted
    drive(0, 1, 1, 1, 1, 2'b10, 4'd13, 4'd2, 4'd3);
    expect_val("sf_dx", S_DX_DST, 16'd0);
    expect_val("sf_xm", S_XM_DST, 16'd7);
`ifdef PIPE_CTRL_STATS_EN
    expect_val("sf_bc", S_BC, 16'd3);
`endif
    tick();
    drive(0, 0, 1, 1, 1, 2'b10, 4'd13, 4'd2, 4'd3);
    expect_val("fl_dx", S_DX_DST, 16'd0);
    expect_val("fl_mtr", S_DX_MTR, 16'd0);
`ifdef PIPE_CTRL_STATS_EN
    expect_val("fl_bc", S_BC, 16'd4);
`endif
    tick();
    drive(0, 0, 0, 0, 1, 2'b10, 4'd13, 4'd2, 4'd3);
    expect_val("nop_dx", S_DX_DST, 16'd0);
    expect_val("nop_mtr", S_DX_MTR, 16'd0);
`ifdef PIPE_CTRL_STATS_EN
    expect_val("nop_bc", S_BC, 16'd4);
`endif
    tick();
    idle(3);

    // missed stall sets sticky fwd_err
    drive(0, 0, 0, 1, 1, 2'b11, 4'd4, 4'd1, 4'd1);
    tick();
    drive(0, 0, 0, 1, 1, 2'b00, 4'd8, 4'd1, 4'd4);
    expect_val("ms_err_pre", S_ERR, 16'h0);
    expect_val("ms_fb_pre", S_FB, 16'h0);
    tick();
    drive(0, 0, 0, 0, 0, 2'b00, 4'd0, 4'd0, 4'd0);
    expect_val("ms_err_set", S_ERR, 16'h1);
    tick();
    idle(3);
    expect_val("ms_err_sticky", S_ERR, 16'h1);
    drain();
    rst_n = 1'b0;
    #1;
    expect_val("ms_err_reset", S_ERR, 16'h0);
    expect_val("rst2_mw_rw", S_MW_RW, 16'h0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_tracker.md
Name: pipe_ctrl_tracker

Overview:
- Carries the per-instruction register-usage fields of the 5-stage 16-bit pipeline through the D/X, X/M and M/W stage registers.
- Acts on the stall and flush requests raised by the hazard detector, inserting bubbles where required.
- Feeds the hazard detector the D/X destination register and writeback class, and the M/W destination register it needs.
- Generates the EX-stage forwarding-mux selects from the tracked stage state.

Parameters:
- REG_W, 4, register-index width (16 architectural registers; R0 is hard-wired zero).
- MTR_W, 2, writeback-select width; value 2'b11 means load (LW).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- freeze  in  1  global pipeline hold (memory busy); all stage registers keep their values.
- stall  in  1  load-use stall from the hazard detector; a bubble enters D/X.
- flush  in  1  taken branch resolved; a bubble enters D/X.
- id_valid  in  1  instruction in decode is real (not a NOP).
- id_reg_write  in  1  decode instruction writes the register file.
- id_mem_to_reg  in  MTR_W  decode writeback select.
- id_dst_reg  in  REG_W  decode destination register.
- id_src1  in  REG_W  decode source register 1.
- id_src2  in  REG_W  decode source register 2.
- dx_mem_to_reg  out  MTR_W  D/X writeback select (to hazard detector).
- dx_dst_reg  out  REG_W  D/X destination (to hazard detector).
- xm_dst_reg  out  REG_W  X/M destination.
- mw_dst_reg  out  REG_W  M/W destination (to hazard detector bypass check).
- mw_reg_write  out  1  M/W register-file write enable.
- fwd_a_sel  out  2  EX operand A select: 00 = RF, 10 = X/M, 01 = M/W.
- fwd_b_sel  out  2  EX operand B select, same encoding.
- fwd_err  out  1  sticky flag: load result needed from X/M, i.e. the hazard detector missed a stall.

Behaviour:
- Each stage register holds: valid, reg_write, mem_to_reg, dst. D/X additionally holds src1 and src2.
- Reset (rst_n low, asynchronous): every field of every stage clears to 0 and fwd_err clears to 0. Consequently every output is 0 during and after reset until the first capture.
- Advance happens on each rising edge where freeze=0:
  - X/M is loaded from D/X, and M/W is loaded from X/M.
  - D/X is loaded from the id_* inputs, unless stall or flush is 1. In that case D/X is loaded with a bubble: all fields 0, including src1 and src2.
- Precedence when events coincide:
  - freeze=1 overrides stall and flush. No stage changes, and the stall is not lost: the hazard detector keeps asserting it.
  - stall and flush together produce a single bubble.
- id_valid=0 is captured as a bubble: all D/X fields 0, regardless of the other id_* inputs.
- Latency: an id_* value appears on dx_* 1 cycle after capture, on xm_dst_reg after 2 cycles, and on mw_* after 3 cycles.
- Outputs dx_*, xm_*, mw_* drive the stage fields directly. Invalid stages read as 0.
- Forwarding selects are combinational from registered state and are evaluated per operand; for operand A, src = D/X src1 (operand B uses src2 identically):
  - If D/X is valid and X/M is valid with reg_write=1, dst≠0, dst==src and mem_to_reg≠2'b11, the select is 10.
  - Otherwise, if M/W is valid with reg_write=1, dst≠0 and dst==src, the select is 01. This applies to loads as well.
  - Otherwise the select is 00.
  - The X/M match has priority because it holds the newer value.
- A source equal to R0 never forwards.
- fwd_err is set on any edge where freeze=0, D/X is valid, and X/M is a valid load whose dst≠0 matches D/X src1 or src2. Once set, only reset clears it.
- No wrap-around or overflow exists outside the optional counter.

Optional Feature:
- Macro PIPE_CTRL_STATS_EN.
- When defined:
  - Adds output bubble_cnt (16 bits), which increments on every edge that captures a stall/flush bubble into D/X.
  - bubble_cnt saturates at 16'hFFFF, does not count while freeze=1, and resets to 0.
- When undefined: the port and the counter are absent, and all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with nonzero id_* inputs and clock running → all outputs 0. Deassert rst_n, capture dst=R3 with reg_write=1 → dx_dst_reg=3 after 1 edge, xm_dst_reg=3 after 2, mw_dst_reg=3 with mw_reg_write=1 after 3.
- EX-EX forwarding: ADD to R5, then SUB reading src1=R5, src2=R2 → in the cycle SUB is in D/X, fwd_a_sel=10 and fwd_b_sel=00. Same sequence with one unrelated instruction between them → fwd_a_sel=01.
- Load-use: LW to R4 (mem_to_reg=11), then ADD reading src2=R4 with stall=1 for one cycle → dx_dst_reg=0 after the stall edge. The stalled ADD is re-captured next; when ADD is in D/X, fwd_b_sel=01 and fwd_err=0.
- Missed stall: same load-use sequence with stall held 0 → fwd_err=1 after the edge where ADD is in D/X and LW is in X/M; fwd_err stays 1 until reset.
- Freeze precedence: freeze=1 and stall=1 together for 3 cycles → all stage outputs unchanged. With PIPE_CTRL_STATS_EN, bubble_cnt is unchanged; after freeze drops and one stall edge, bubble_cnt increments by 1.
- R0 and flush: instruction writing R0, followed by a reader of R0 → selects stay 00. Assert flush together with stall for one edge → exactly one bubble, and bubble_cnt increments by exactly 1.
